// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor
//   Receive-side conditioner for the I2C pads. Each raw line is synchronised
//   into the clk domain, then glitch-filtered. SCL edges, START, STOP and an
//   optional SCL-low timeout are reported as single-cycle pulses. A bus-busy
//   flag tracks START..STOP.
//
//   Optional feature macro: I2C_BUS_MONITOR_TIMEOUT_EN
//     defined   -> SCL-low timeout counter is built (TIMEOUT_CYCLES)
//     undefined -> timeout tied to 0, bus_busy clears only on STOP
//
// Ports
//   clk, rst            clock (posedge), synchronous active-high reset
//   scl_i, sda_i        raw asynchronous pad levels
//   scl_f, sda_f        filtered line levels
//   scl_rise, scl_fall  one-cycle pulses on filtered SCL edges
//   start_det, stop_det one-cycle pulses on START / repeated START / STOP
//   bus_busy            high from START until STOP (or timeout)
//   timeout             one-cycle pulse on SCL held low too long while busy

// Per-line synchroniser + glitch filter. filt_nxt exposes the value the
// filter register will take on the next edge so that edge events can be
// registered and line up with the visible filtered level.
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic filt,
  output logic filt_nxt
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q, cnt_nxt;
  logic                   filt_q;

  // Reset to 1 so an idle (pulled-up) bus is assumed out of reset.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after it disagrees with the filtered
  // level for FILTER_LEN consecutive samples; any agreement restarts it.
  always_comb begin
    filt_nxt = filt_q;
    cnt_nxt  = '0;
    if (s != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_nxt = s;
      else                              cnt_nxt  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  assign filt = filt_q;
endmodule

module i2c_bus_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic timeout
);
  localparam int NUM_LINES = 2;  // lane 0 = SCL, lane 1 = SDA

  logic [NUM_LINES-1:0] pad, filt, filt_nxt;
  assign pad = {sda_i, scl_i};

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_filt (
      .clk      (clk),
      .rst      (rst),
      .pad      (pad[g]),
      .filt     (filt[g]),
      .filt_nxt (filt_nxt[g])
    );
  end

  assign scl_f = filt[0];
  assign sda_f = filt[1];

  logic scl_n, sda_n, scl_hold_hi;
  assign scl_n = filt_nxt[0];
  assign sda_n = filt_nxt[1];
  // SCL high now and staying high: an SDA edge here is a bus condition.
  // A simultaneous SCL change suppresses START/STOP.
  assign scl_hold_hi = scl_f & scl_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_rise  <= ~scl_f &  scl_n;
      scl_fall  <=  scl_f & ~scl_n;
      start_det <= scl_hold_hi &  sda_f & ~sda_n;
      stop_det  <= scl_hold_hi & ~sda_f &  sda_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        bus_busy <= 1'b0;
    else if (start_det)             bus_busy <= 1'b1;
    else if (stop_det || timeout)   bus_busy <= 1'b0;
  end

`ifdef I2C_BUS_MONITOR_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] to_cnt;
  logic          to_fired;  // blocks retrigger until SCL is seen high again
  logic          to_q;
  logic          to_run;

  assign to_run = bus_busy & ~scl_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt   <= '0;
      to_fired <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      to_q <= 1'b0;
      if (!to_run) begin
        to_cnt <= '0;
      end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        to_cnt   <= '0;
        to_q     <= ~to_fired;
        to_fired <= 1'b1;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (scl_f) to_fired <= 1'b0;
    end
  end

  assign timeout = to_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Scoreboard bench for i2c_bus_monitor. A reference model samples the pads
// each edge and pushes expected event records; a monitor pops one record for
// every pulse the DUT shows. Directed scenarios add latency and count checks.
module tb_i2c_bus_monitor;
  localparam int SYNC = 2;
  localparam int FLEN = 3;
  localparam int TOC  = 16;

  logic clk = 1'b0;
  logic rst, scl_i, sda_i;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout;

  always #5 clk = ~clk;

  i2c_bus_monitor #(
    .SYNC_STAGES    (SYNC),
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_f     (scl_f),
    .sda_f     (sda_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy),
    .timeout   (timeout)
  );

  typedef struct {
    int         cyc;
    logic [4:0] ev;   // {timeout, stop, start, fall, rise}
    logic       busy;
    logic       sf;
    logic       df;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0;
  int ph_rise = 0, ph_fall = 0, ph_start = 0, ph_stop = 0, ph_to = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Line level = last value that persisted FLEN samples after SYNC edges of
  // delay; events come from comparing consecutive accepted levels.
  bit m_qs[$], m_qd[$];
  bit m_fs, m_fd, m_busy, m_fired;
  bit m_ps, m_pp, m_pt;  // pulses shown last cycle that affect bus_busy
  int m_rs, m_rd, m_low;
  bit os, od, ob, ss, sd, to, rs, fl, st, sp;
  exp_t m_e;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_qs.delete(); m_qd.delete();
      for (int i = 0; i < SYNC; i++) begin m_qs.push_back(1'b1); m_qd.push_back(1'b1); end
      m_fs = 1; m_fd = 1; m_busy = 0; m_fired = 0;
      m_ps = 0; m_pp = 0; m_pt = 0; m_rs = 0; m_rd = 0; m_low = 0;
    end else begin
      os = m_fs; od = m_fd; ob = m_busy;
      ss = m_qs.pop_front(); m_qs.push_back(scl_i);
      sd = m_qd.pop_front(); m_qd.push_back(sda_i);
      if (ss != m_fs) begin m_rs++; if (m_rs == FLEN) begin m_fs = ss; m_rs = 0; end end
      else m_rs = 0;
      if (sd != m_fd) begin m_rd++; if (m_rd == FLEN) begin m_fd = sd; m_rd = 0; end end
      else m_rd = 0;
      to = 0;
`ifdef I2C_BUS_MONITOR_TIMEOUT_EN
      if (os) m_fired = 0;
      if (ob && !os) m_low++; else m_low = 0;
      if (m_low == TOC && !m_fired) begin to = 1; m_fired = 1; end
`endif
      if (m_ps) m_busy = 1;
      else if (m_pp || m_pt) m_busy = 0;
      rs = !os && m_fs;
      fl = os && !m_fs;
      st = os && m_fs && od && !m_fd;
      sp = os && m_fs && !od && m_fd;
      m_ps = st; m_pp = sp; m_pt = to;
      if (rs || fl || st || sp || to) begin
        m_e.cyc = cyc; m_e.ev = {to, sp, st, fl, rs};
        m_e.busy = m_busy; m_e.sf = m_fs; m_e.df = m_fd;
        sb.push_back(m_e);
      end
    end
  end

  // ---------------- monitor ----------------
  logic [4:0] mon_ev;
  exp_t mon_e;
  always @(negedge clk) begin
    mon_ev = {timeout, stop_det, start_det, scl_fall, scl_rise};
    if (mon_ev != 5'd0) begin
      ph_rise += int'(scl_rise); ph_fall += int'(scl_fall);
      ph_start += int'(start_det); ph_stop += int'(stop_det); ph_to += int'(timeout);
      if (sb.size() == 0) begin
        chk("unexpected_event", {27'd0, mon_ev}, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("ev_cycle", cyc, mon_e.cyc);
        chk("ev_kind", {27'd0, mon_ev}, {27'd0, mon_e.ev});
        chk("ev_busy", {31'd0, bus_busy}, {31'd0, mon_e.busy});
        chk("ev_scl_f", {31'd0, scl_f}, {31'd0, mon_e.sf});
        chk("ev_sda_f", {31'd0, sda_f}, {31'd0, mon_e.df});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit d, input int n);
    scl_i = s; sda_i = d;
    tick(n);
  endtask

  task automatic clr();
    ph_rise = 0; ph_fall = 0; ph_start = 0; ph_stop = 0; ph_to = 0;
  endtask

  // Edges until the selected output reaches val; -1 if the bound expires.
  task automatic wait_for(input int which, input bit val, input int lim, output int n);
    logic v;
    n = -1;
    for (int k = 1; k <= lim; k++) begin
      tick(1);
      case (which)
        0: v = scl_f;
        1: v = sda_f;
        default: v = timeout;
      endcase
      if (v === val) begin n = k; break; end
    end
  endtask

  int n, m;
  bit d;

  initial begin
    rst = 1; scl_i = 0; sda_i = 0;
    // reset with a low bus
    tick(1);
    chk("rst_scl_f", scl_f, 1); chk("rst_sda_f", sda_f, 1);
    chk("rst_busy", bus_busy, 0);
    chk("rst_pulses", {timeout, stop_det, start_det, scl_fall, scl_rise}, 0);
    tick(1);
    rst = 0;
    tick(1);
    chk("post_rst_scl_f", scl_f, 1); chk("post_rst_sda_f", sda_f, 1);
    chk("post_rst_busy", bus_busy, 0);
    chk("post_rst_pulses", {timeout, stop_det, start_det, scl_fall, scl_rise}, 0);
    wait_for(0, 1'b0, 20, n);
    chk("rst_release_latency", n + 1, 5);

    // back to idle
    drive(1, 0, 10);
    drive(1, 1, 10);

    // glitch rejection
    clr();
    drive(1, 0, FLEN - 1);
    drive(1, 1, 10);
    chk("glitch_sda_f", sda_f, 1);
    chk("glitch_no_start", ph_start, 0);
    sda_i = 0;
    wait_for(1, 1'b0, 20, n);
    chk("start_latency", n, 5);
    chk("start_pulse", start_det, 1);
    chk("start_busy_before", bus_busy, 0);
    tick(1);
    chk("start_busy_after", bus_busy, 1);
    chk("start_one_cycle", start_det, 0);
    tick(8);
    chk("start_count", ph_start, 1);

    // repeated START
    clr();
    drive(0, 0, 8); drive(0, 1, 8); drive(1, 1, 8); drive(1, 0, 8);
    chk("rstart_count", ph_start, 1);
    chk("rstart_busy", bus_busy, 1);

    // STOP
    clr();
    drive(0, 0, 8); drive(1, 0, 8);
    sda_i = 1;
    wait_for(1, 1'b1, 20, n);
    chk("stop_pulse", stop_det, 1);
    chk("stop_busy_before", bus_busy, 1);
    tick(1);
    chk("stop_busy_after", bus_busy, 0);
    tick(6);
    chk("stop_count", ph_stop, 1);
    chk("stop_no_start", ph_start, 0);

    // data bits
    drive(1, 0, 8);
    clr();
    d = 0;
    for (int b = 0; b < 8; b++) begin
      drive(0, d, 8);
      d = 1'($urandom_range(0, 1));
      drive(0, d, 8);
      drive(1, d, 8);
    end
    chk("data_rise", ph_rise, 8); chk("data_fall", ph_fall, 8);
    chk("data_start", ph_start, 0); chk("data_stop", ph_stop, 0);
    drive(0, 0, 8); drive(1, 0, 8); drive(1, 1, 8);
    chk("data_end_busy", bus_busy, 0);

    // simultaneous SCL/SDA fall while busy
    drive(1, 0, 8); drive(0, 0, 8); drive(0, 1, 8); drive(1, 1, 8);
    clr();
    scl_i = 0; sda_i = 0;
    wait_for(0, 1'b0, 20, n);
    chk("simul_latency", n, 5);
    chk("simul_fall", scl_fall, 1);
    chk("simul_no_start", start_det, 0);
    chk("simul_sda_f", sda_f, 0);
    tick(1);
    chk("simul_busy", bus_busy, 1);
    chk("simul_start_count", ph_start, 0);
    drive(1, 0, 8); drive(1, 1, 8);
    chk("simul_end_busy", bus_busy, 0);

    // SCL-low timeout
    drive(1, 0, 8);
    clr();
    scl_i = 0;
    wait_for(0, 1'b0, 20, n);
`ifdef I2C_BUS_MONITOR_TIMEOUT_EN
    wait_for(2, 1'b1, 40, m);
    chk("timeout_latency", m, TOC);
    tick(1);
    chk("timeout_busy", bus_busy, 0);
    tick(30);
    chk("timeout_count", ph_to, 1);
`else
    tick(40);
    chk("timeout_never", ph_to, 0);
    chk("timeout_busy_held", bus_busy, 1);
`endif
    drive(1, 0, 8); drive(1, 1, 8);

    // randomized pad activity, including short glitches and a mid-run reset
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin rst = 1; tick(2); rst = 0; end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
    end
    drive(1, 1, 12);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
